// File: rtl/sevenseg_scan_capture.sv
// sevenseg_scan_capture: rebuilds the hex digits shown on a scanned 8-digit seven-segment bus.
// Optional macro SEVENSEG_CAPTURE_DP_EN: include dp in the stability check and capture it into dp_bits.
module sevenseg_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic [6:0]              seg,
    input  logic                    dp,
    input  logic [2:0]              rd_sel,
    output logic [3:0]              rd_num,
    output logic                    rd_valid,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    frame_valid,
    output logic                    seg_err,
    output logic                    anode_err,
    output logic [NUM_DIGITS-1:0]   dp_bits
);
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t r_state, w_state_next;
    logic [NUM_DIGITS-1:0] w_low, r_prev_anode, r_valid, r_seen, w_seen_next, w_wr_mask;
    logic [4*NUM_DIGITS-1:0] r_dig, w_dig_next;
    logic [6:0] r_prev_seg;
    logic [7:0] r_cnt, w_cnt_next;
    logic [3:0] w_nib;
    logic [2:0] w_idx;
    logic w_dec_ok, w_onehot, w_multi, r_multi, w_change, w_cap, w_wr, w_frame;
    assign w_low    = ~anode;
    assign w_onehot = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);
    assign w_multi  = (w_low != '0) && !w_onehot;
`ifdef SEVENSEG_CAPTURE_DP_EN
    logic r_prev_dp;
    assign w_change = (anode != r_prev_anode) || (seg != r_prev_seg) || (dp != r_prev_dp);
`else
    logic w_unused_dp;
    assign w_unused_dp = dp;
    assign w_change = (anode != r_prev_anode) || (seg != r_prev_seg);
`endif
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (w_low[k]) w_idx = 3'(k);
    end
    always_comb begin
        w_dec_ok = 1'b1;
        w_nib = '0;
        case (seg)
            7'b0000001: w_nib = 4'h0;
            7'b1001111: w_nib = 4'h1;
            7'b0010010: w_nib = 4'h2;
            7'b0000110: w_nib = 4'h3;
            7'b1001100: w_nib = 4'h4;
            7'b0100100: w_nib = 4'h5;
            7'b0100000: w_nib = 4'h6;
            7'b0001111: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0000100: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b1100000: w_nib = 4'hB;
            7'b0110001: w_nib = 4'hC;
            7'b1000010: w_nib = 4'hD;
            7'b0110000: w_nib = 4'hE;
            7'b0111000: w_nib = 4'hF;
            default:    w_dec_ok = 1'b0;
        endcase
    end
    // r_cnt counts cycles the current pattern has been seen; a change always wins over the threshold
    always_comb begin
        w_state_next = r_state;
        w_cnt_next = r_cnt;
        w_cap = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_onehot) begin
                    w_state_next = SETTLE;
                    w_cnt_next = 8'd1;
                end
            end
            SETTLE: begin
                if (w_change) begin
                    w_state_next = w_onehot ? SETTLE : IDLE;
                    w_cnt_next = 8'd1;
                end else if (r_cnt >= STABLE) begin
                    w_cap = 1'b1;
                    w_state_next = HOLD;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                if (w_change) begin
                    w_state_next = w_onehot ? SETTLE : IDLE;
                    w_cnt_next = 8'd1;
                end
            end
        endcase
    end
    assign w_wr      = w_cap && w_dec_ok;
    assign w_wr_mask = w_wr ? w_low : '0;
    assign w_seen_next = r_seen | w_wr_mask;
    assign w_frame   = (w_seen_next == '1);
    always_comb begin
        w_dig_next = r_dig;
        if (w_wr) w_dig_next[4*w_idx +: 4] = w_nib;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_prev_anode <= '0;
            r_prev_seg <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt <= w_cnt_next;
            r_prev_anode <= anode;
            r_prev_seg <= seg;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dig <= '0;
            r_valid <= '0;
            r_seen <= '0;
            r_multi <= 1'b0;
            digits <= '0;
            frame_valid <= 1'b0;
            seg_err <= 1'b0;
            anode_err <= 1'b0;
            rd_num <= '0;
            rd_valid <= 1'b0;
        end else begin
            r_dig <= w_dig_next;
            r_valid <= r_valid | w_wr_mask;
            r_seen <= w_frame ? '0 : w_seen_next;
            r_multi <= w_multi;
            frame_valid <= w_frame;
            seg_err <= w_cap && !w_dec_ok;
            anode_err <= w_multi && !r_multi;
            rd_num <= r_dig[4*rd_sel +: 4];
            rd_valid <= r_valid[rd_sel];
            if (w_frame) digits <= w_dig_next;
        end
    end
`ifdef SEVENSEG_CAPTURE_DP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_dp <= 1'b0;
            dp_bits <= '0;
        end else begin
            r_prev_dp <= dp;
            if (w_wr) dp_bits[w_idx] <= ~dp;
        end
    end
`else
    assign dp_bits = '0;
`endif
endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// tb_sevenseg_scan_capture: directed checks of digit capture, filtering, error pulses and reset.
module tb_sevenseg_scan_capture;
`ifdef SEVENSEG_CAPTURE_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, dp = 1'b1;
    logic [7:0] anode = 8'hFF;
    logic [6:0] seg = 7'h7F;
    logic [2:0] rd_sel = '0;
    logic [3:0] rd_num;
    logic rd_valid, frame_valid, seg_err, anode_err;
    logic [31:0] digits;
    logic [7:0] dp_bits;
    int total = 0, bad = 0;
    int n_fv = 0, n_se = 0, n_ae = 0;
    int b_fv, b_se, b_ae;

    sevenseg_scan_capture #(.STABLE_CYCLES(4), .NUM_DIGITS(8)) dut (
        .clk(clk), .reset(reset), .anode(anode), .seg(seg), .dp(dp), .rd_sel(rd_sel),
        .rd_num(rd_num), .rd_valid(rd_valid), .digits(digits), .frame_valid(frame_valid),
        .seg_err(seg_err), .anode_err(anode_err), .dp_bits(dp_bits)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) n_fv++;
        if (seg_err) n_se++;
        if (anode_err) n_ae++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] s7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [7:0] an(input int i);
        return ~(8'd1 << i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
        anode = a;
        seg = s;
        dp = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [31:0] vals, input logic [7:0] dps, input int bad_digit, input int ndig);
        for (int i = 0; i < ndig; i++)
            drive(an(i), (i == bad_digit) ? 7'h7F : s7(vals[4*i +: 4]), dps[i], 10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        anode = 8'hFF;
        seg = 7'h7F;
        dp = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rd(input logic [2:0] s);
        rd_sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic base();
        b_fv = n_fv;
        b_se = n_se;
        b_ae = n_ae;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", digits, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_seg_err", seg_err, 0);
        chk("rst_anode_err", anode_err, 0);
        chk("rst_rd_num", rd_num, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_dp_bits", dp_bits, 0);
        reset = 1'b0;

        base();
        scan(32'hF413A97D, 8'hFF, -1, 8);
        drive(8'hFF, 7'h7F, 1'b1, 3);
        chk("scan_frames", n_fv - b_fv, 1);
        chk("scan_digits", digits, 32'hF413A97D);
        chk("scan_fv_low", frame_valid, 0);
        chk("scan_seg_err", n_se - b_se, 0);
        rd(3'd3);
        chk("scan_rd_num3", rd_num, 4'hA);
        chk("scan_rd_valid3", rd_valid, 1);
        rd(3'd7);
        chk("scan_rd_num7", rd_num, 4'hF);

        base();
        scan(32'h0000CAFE, 8'hFF, -1, 4);
        drive(an(4), s7(4'h5), 1'b1, 2);
        chk("pre_rst_rd_valid", rd_valid, 1);
        chk("partial_no_frame", n_fv - b_fv, 0);
        chk("partial_digits_kept", digits, 32'hF413A97D);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_digits", digits, 0);
        chk("async_rst_rd_valid", rd_valid, 0);
        chk("async_rst_rd_num", rd_num, 0);
        chk("async_rst_fv", frame_valid, 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        base();
        scan(32'h76543210, 8'hFF, -1, 8);
        drive(8'hFF, 7'h7F, 1'b1, 3);
        chk("post_rst_frames", n_fv - b_fv, 1);
        chk("post_rst_digits", digits, 32'h76543210);
        rd(3'd6);
        chk("post_rst_rd_num6", rd_num, 4'h6);

        do_reset();
        rd_sel = 3'd2;
        drive(an(2), s7(4'hD), 1'b1, 3);
        chk("glitch_d_not_valid", rd_valid, 0);
        drive(an(2), s7(4'h9), 1'b1, 5);
        drive(8'hFF, 7'h7F, 1'b1, 3);
        chk("glitch_valid2", rd_valid, 1);
        chk("glitch_num2", rd_num, 4'h9);
        rd_sel = 3'd1;
        drive(an(1), s7(4'h5), 1'b1, 4);
        drive(8'hFF, 7'h7F, 1'b1, 3);
        chk("short_dwell_no_capture", rd_valid, 0);

        do_reset();
        base();
        drive(8'b11110011, s7(4'h1), 1'b1, 6);
        drive(8'hFF, 7'h7F, 1'b1, 4);
        chk("multi_hot_err_once", n_ae - b_ae, 1);
        rd(3'd2);
        chk("multi_hot_no_cap2", rd_valid, 0);
        rd(3'd3);
        chk("multi_hot_no_cap3", rd_valid, 0);
        drive(8'hFF, 7'h7F, 1'b1, 4);
        chk("blank_no_err", n_ae - b_ae, 1);
        rd_sel = 3'd2;
        drive(an(2), s7(4'hC), 1'b1, 5);
        drive(8'hFF, 7'h7F, 1'b1, 2);
        chk("after_multi_recover", rd_num, 4'hC);

        do_reset();
        base();
        drive(an(5), 7'h7F, 1'b1, 8);
        drive(8'hFF, 7'h7F, 1'b1, 2);
        chk("undecodable_seg_err", n_se - b_se, 1);
        rd(3'd5);
        chk("undecodable_not_valid", rd_valid, 0);
        base();
        scan(32'h01234567, 8'hFF, 5, 8);
        drive(8'hFF, 7'h7F, 1'b1, 3);
        chk("bad_digit_no_frame", n_fv - b_fv, 0);
        chk("bad_digit_seg_err", n_se - b_se, 1);
        chk("bad_digit_digits", digits, 0);

        do_reset();
        rd_sel = 3'd0;
        for (int i = 0; i < 5; i++) drive(an(0), s7(4'h8), i[0], 1);
        drive(8'hFF, 7'h7F, 1'b1, 2);
        chk("dp_toggle_capture", rd_valid, DP_EN ? 32'd0 : 32'd1);
        scan(32'h12345678, 8'hFE, -1, 8);
        drive(8'hFF, 7'h7F, 1'b1, 3);
        chk("dp_bits", dp_bits, DP_EN ? 32'h01 : 32'h00);
        chk("dp_frame_digits", digits, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
